// File: rtl/ctech_lib_clk_div_prog.sv
// ctech_lib_clk_div_prog
// Multi-channel programmable clock divider. Each channel makes a flop-driven
// divided clock plus a one-cycle clock enable that precedes every rising edge.
// Ratio changes and stops only take effect at period boundaries, so no
// divided-clock pulse is ever glitched or truncated.
//
// Optional feature macro: CTECH_CLK_DIV_DUTY50_EN
//   When defined, each channel adds a falling-edge flop so odd ratios give an
//   exact 50% duty cycle. When undefined, odd ratios give floor(N/2) high
//   cycles and ceil(N/2) low cycles.
//
// Ports
//   clk        source clock (rising edge; falling edge too with the macro)
//   rst_b      asynchronous active-low reset
//   div_ratio  requested ratio per channel, channel c at [c*DIV_W +: DIV_W]
//   div_en     per-channel run enable (level)
//   upd_req    per-channel ratio-update request (level, held until ack)
//   upd_ack    one-cycle pulse after the requested ratio was latched
//   clkout     divided clocks
//   clken      one-cycle pulse in the cycle before each clkout rising edge
module ctech_lib_clk_div_prog #(
    parameter int unsigned NUM_CH = 1,
    parameter int unsigned DIV_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic [NUM_CH*DIV_W-1:0]   div_ratio,
    input  logic [NUM_CH-1:0]         div_en,
    input  logic [NUM_CH-1:0]         upd_req,
    output logic [NUM_CH-1:0]         upd_ack,
    output logic [NUM_CH-1:0]         clkout,
    output logic [NUM_CH-1:0]         clken
);

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE      = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN       = 2'd1;
    localparam logic [ST_W-1:0] ST_STOP_PEND = 2'd2;

    // Ratios below 2 cannot form a clock; they are stored as 2.
    function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] r);
        return (r < DIV_W'(2)) ? DIV_W'(2) : r;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

        logic [ST_W-1:0]  state_q;
        logic [ST_W-1:0]  state_d;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] cnt_d;
        logic [DIV_W-1:0] ratio_q;
        logic [DIV_W-1:0] ratio_d;
        logic             clk_q;
        logic             clk_d;
        logic             clken_q;
        logic             clken_d;
        logic             ack_q;
        logic             latch;
        logic             at_end;

        // State, counter and registered outputs.
        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                ratio_q <= DIV_W'(2);
                clk_q   <= 1'b0;
                clken_q <= 1'b0;
                ack_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ratio_q <= ratio_d;
                clk_q   <= clk_d;
                clken_q <= clken_d;
                ack_q   <= latch;
            end
        end

        // Next state, counter, ratio latch; outputs are derived from the
        // next counter value so clkout rises on the edge that enters cnt=0.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ratio_d = ratio_q;
            latch   = 1'b0;
            at_end  = (cnt_q == (ratio_q - DIV_W'(1)));

            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    latch = upd_req[c];
                    if (div_en[c]) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    latch = upd_req[c] && at_end;
                    cnt_d = at_end ? '0 : (cnt_q + DIV_W'(1));
                    if (!div_en[c]) begin
                        state_d = ST_STOP_PEND;
                    end
                end
                ST_STOP_PEND: begin
                    latch = upd_req[c] && at_end;
                    cnt_d = at_end ? '0 : (cnt_q + DIV_W'(1));
                    if (div_en[c]) begin
                        state_d = ST_RUN;
                    end else if (at_end) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (latch) begin
                ratio_d = clamp_ratio(div_ratio[c*DIV_W +: DIV_W]);
            end

            clk_d   = (state_d != ST_IDLE) && (cnt_d < (ratio_d >> 1));
            clken_d = (state_d == ST_RUN) && (cnt_d == (ratio_d - DIV_W'(1)));
        end

        assign upd_ack[c] = ack_q;
        assign clken[c]   = clken_q;

`ifdef CTECH_CLK_DIV_DUTY50_EN
        logic fall_q;

        // Half-cycle delayed copy stretches the high phase of odd ratios.
        always_ff @(negedge clk or negedge rst_b) begin
            if (!rst_b) begin
                fall_q <= 1'b0;
            end else begin
                fall_q <= clk_q;
            end
        end

        // fall_q is low at every period boundary, so a ratio change is clean.
        assign clkout[c] = clk_q | (fall_q & ratio_q[0]);
`else
        assign clkout[c] = clk_q;
`endif

    end

endmodule

// File: tb/tb_ctech_lib_clk_div_prog.sv
// Directed bench for ctech_lib_clk_div_prog (two channels, 4-bit ratios).
module tb_ctech_lib_clk_div_prog;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DIV_W  = 4;

    logic                    clk;
    logic                    rst_b;
    logic [NUM_CH*DIV_W-1:0] div_ratio;
    logic [NUM_CH-1:0]       div_en;
    logic [NUM_CH-1:0]       upd_req;
    logic [NUM_CH-1:0]       upd_ack;
    logic [NUM_CH-1:0]       clkout;
    logic [NUM_CH-1:0]       clken;

    int passed = 0;
    int total  = 0;
    int waited;

    logic [11:0] exp_a_clk = 12'h333;
    logic [11:0] exp_a_en  = 12'h888;
    logic [5:0]  exp_c_clk = 6'b000111;
    logic [5:0]  exp_c_en  = 6'b100000;
    logic [6:0]  exp_d_clk = 7'b1000111;
    logic [6:0]  exp_d_en  = 7'b0100000;
`ifdef CTECH_CLK_DIV_DUTY50_EN
    logic [4:0]  exp_e_pos = 5'b00111;
    logic [5:0]  exp_f1_clk = 6'b011011;
`else
    logic [4:0]  exp_e_pos = 5'b00011;
    logic [5:0]  exp_f1_clk = 6'b001001;
`endif
    logic [4:0]  exp_e_neg = 5'b00011;
    logic [5:0]  exp_f0_clk = 6'b010101;
    logic [5:0]  exp_f0_en  = 6'b101010;
    logic [5:0]  exp_f1_en  = 6'b100100;

    ctech_lib_clk_div_prog #(
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .div_ratio (div_ratio),
        .div_en    (div_en),
        .upd_req   (upd_req),
        .upd_ack   (upd_ack),
        .clkout    (clkout),
        .clken     (clken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        rst_b     = 1'b0;
        div_ratio = '0;
        div_en    = '0;
        upd_req   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_clkout", int'(clkout), 0);
        chk("rst_clken", int'(clken), 0);
        chk("rst_ack", int'(upd_ack), 0);
        rst_b = 1'b1;
        tick();
        chk("idle_clkout", int'(clkout), 0);
        chk("idle_ack", int'(upd_ack), 0);

        // A: enable together with update to N=4
        div_ratio = {4'd0, 4'd4};
        upd_req   = 2'b01;
        div_en    = 2'b01;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("a_clkout", int'(clkout[0]), int'(exp_a_clk[k]));
            chk("a_clken", int'(clken[0]), int'(exp_a_en[k]));
            if (k < 2) chk("a_ack", int'(upd_ack[0]), (k == 0) ? 1 : 0);
            if (k == 0) upd_req = 2'b00;
        end
        chk("a_ch1_idle", int'(clkout[1]), 0);

        // C: update to N=6 requested at cnt=1 of N=4
        tick();
        chk("c_cnt0", int'(clkout[0]), 1);
        tick();
        chk("c_cnt1", int'(clkout[0]), 1);
        div_ratio = {4'd0, 4'd6};
        upd_req   = 2'b01;
        for (int j = 0; j < 2; j++) begin
            tick();
            chk("c_pre_clk", int'(clkout[0]), 0);
            chk("c_pre_ack", int'(upd_ack[0]), 0);
            chk("c_pre_en", int'(clken[0]), (j == 1) ? 1 : 0);
        end
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("c_clkout", int'(clkout[0]), int'(exp_c_clk[j]));
            chk("c_clken", int'(clken[0]), int'(exp_c_en[j]));
            chk("c_ack", int'(upd_ack[0]), (j == 0) ? 1 : 0);
            if (j == 0) upd_req = 2'b00;
        end

        // D: stop at cnt=1 of N=6, then restart and toggle during STOP_PEND
        tick();
        chk("d_cnt0", int'(clkout[0]), 1);
        tick();
        chk("d_cnt1", int'(clkout[0]), 1);
        div_en = 2'b00;
        tick();
        chk("d_stop_hi", int'(clkout[0]), 1);
        chk("d_stop_en", int'(clken[0]), 0);
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("d_stop_lo", int'(clkout[0]), 0);
            chk("d_stop_en_lo", int'(clken[0]), 0);
        end
        div_en = 2'b01;
        for (int j = 0; j < 7; j++) begin
            tick();
            chk("d_restart_clk", int'(clkout[0]), int'(exp_d_clk[j]));
            chk("d_restart_en", int'(clken[0]), int'(exp_d_en[j]));
            if (j == 1) div_en = 2'b00;
            if (j == 2) div_en = 2'b01;
        end

        // E: odd ratio N=5 (update requested at cnt=0 of N=6)
        div_ratio = {4'd0, 4'd5};
        upd_req   = 2'b01;
        waited    = 0;
        do begin
            tick();
            waited++;
        end while (!upd_ack[0] && waited < 12);
        chk("e_ack_latency", waited, 6);
        upd_req = 2'b00;
        for (int j = 0; j < 5; j++) begin
            if (j != 0) tick();
            chk("e_pos", int'(clkout[0]), int'(exp_e_pos[j]));
            @(negedge clk);
            #1;
            chk("e_neg", int'(clkout[0]), int'(exp_e_neg[j]));
        end
        div_en = 2'b00;
        repeat (8) tick();
        chk("e_stopped", int'(clkout[0]), 0);

        // F: clamp (ch0 ratio 0) and independent ch1 ratio 3
        div_ratio = {4'd3, 4'd0};
        upd_req   = 2'b11;
        div_en    = 2'b11;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("f_ch0_clk", int'(clkout[0]), int'(exp_f0_clk[j]));
            chk("f_ch0_en", int'(clken[0]), int'(exp_f0_en[j]));
            chk("f_ch1_clk", int'(clkout[1]), int'(exp_f1_clk[j]));
            chk("f_ch1_en", int'(clken[1]), int'(exp_f1_en[j]));
            if (j == 0) begin
                chk("f_ack", int'(upd_ack), 3);
                upd_req = 2'b00;
            end
        end

        // G: asynchronous reset at cnt=2 of N=8
        div_ratio = {4'd3, 4'd8};
        upd_req   = 2'b01;
        waited    = 0;
        do begin
            tick();
            waited++;
        end while (!upd_ack[0] && waited < 6);
        chk("g_ack_latency", waited, 1);
        upd_req = 2'b00;
        tick();
        tick();
        chk("g_cnt2", int'(clkout[0]), 1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("g_async_clkout", int'(clkout), 0);
        chk("g_async_clken", int'(clken), 0);
        chk("g_async_ack", int'(upd_ack), 0);
        div_en = 2'b00;
        tick();
        rst_b  = 1'b1;
        div_en = 2'b01;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("g_post_clk", int'(clkout[0]), (j % 2 == 0) ? 1 : 0);
            chk("g_post_en", int'(clken[0]), (j % 2 == 1) ? 1 : 0);
            chk("g_post_ch1", int'(clkout[1]), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
